// File: rtl/mem_pkg.sv
// Shared encodings for the icache/dcache arbiter in front of mem_ctrl:
// command opcodes, requester tags, request bit positions and FSM states.
package mem_pkg;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  localparam logic [1:0] TAG_DCACHE = 2'b00;
  localparam logic [1:0] TAG_ICACHE = 2'b01;

  // Bit positions inside the {dc, ic} request/grant vectors
  localparam int REQ_IC = 0;
  localparam int REQ_DC = 1;

  // Last-served pointer values
  localparam logic PTR_IC = 1'b0;
  localparam logic PTR_DC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// whoever was not served last. The pointer register lives in the caller.
module mem_arb_rr
  import mem_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);

  always_comb begin
    grant = reqs;
    if (reqs[REQ_IC] && reqs[REQ_DC]) begin
      grant = (ptr == PTR_IC) ? 2'b10 : 2'b01;
    end

    ptr_next = ptr;
    if (grant[REQ_DC]) begin
      ptr_next = PTR_DC;
    end else if (grant[REQ_IC]) begin
      ptr_next = PTR_IC;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// icache/dcache request arbiter driving mem_ctrl's single command port.
// Optional perf counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITCOUNT = 32,
  parameter int WORD_SIZE     = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ic_req,
  input  logic [ADDR_BITCOUNT-3:0] ic_addr,
  output logic                     ic_done,
  output logic [WORD_SIZE-1:0]     ic_rdata,
  input  logic                     dc_req,
  input  logic                     dc_we,
  input  logic [ADDR_BITCOUNT-3:0] dc_addr,
  input  logic [WORD_SIZE-1:0]     dc_wdata,
  output logic                     dc_done,
  output logic [WORD_SIZE-1:0]     dc_rdata,
  input  logic [ADDR_BITCOUNT-1:0] mem_base,
  input  logic                     ready,
  input  logic                     tx_done,
  input  logic [WORD_SIZE-1:0]     common_data_bus_write_out,
  output logic [1:0]               op,
  output logic [ADDR_BITCOUNT-1:0] raw_address,
  output logic [ADDR_BITCOUNT-1:0] address_offset,
  output logic [WORD_SIZE-1:0]     common_data_bus_read_in,
  output logic                     arb_busy,
  output logic [31:0]              perf_ic_grants,
  output logic [31:0]              perf_dc_grants,
  output logic [31:0]              perf_conflicts
);

  arb_state_t               state;
  logic [1:0]               reqs;
  logic [1:0]               grant;
  logic                     ptr;
  logic                     ptr_next;
  logic                     grant_fire;

  logic                     win_dc;
  logic [1:0]               lat_op;
  logic [ADDR_BITCOUNT-1:0] lat_raw;
  logic [ADDR_BITCOUNT-1:0] lat_off;
  logic [WORD_SIZE-1:0]     lat_wdata;
  logic [WORD_SIZE-1:0]     lat_rdata;

  assign reqs       = {dc_req, ic_req};
  assign grant_fire = (state == ST_IDLE) && ready && (|reqs);

  mem_arb_rr u_rr (
    .reqs     (reqs),
    .ptr      (ptr),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  // Reset leaves the pointer at "icache last served" so dcache wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_IC;
    end else if (grant_fire) begin
      ptr <= ptr_next;
    end
  end

  // Grant-time capture: the request may drop or change once granted
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      win_dc    <= grant[REQ_DC];
      lat_op    <= (grant[REQ_DC] && dc_we) ? OP_WRITE : OP_READ;
      lat_raw   <= grant[REQ_DC] ? {TAG_DCACHE, dc_addr} : {TAG_ICACHE, ic_addr};
      lat_off   <= mem_base;
      lat_wdata <= (grant[REQ_DC] && dc_we) ? dc_wdata : '0;
    end
    if ((state == ST_WAIT) && tx_done && (lat_op == OP_READ)) begin
      lat_rdata <= common_data_bus_write_out;
    end
  end

  // Command outputs trail the state by one edge so every port is a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_IDLE;
      op                      <= OP_IDLE;
      raw_address             <= '0;
      address_offset          <= '0;
      common_data_bus_read_in <= '0;
      ic_done                 <= 1'b0;
      dc_done                 <= 1'b0;
      ic_rdata                <= '0;
      dc_rdata                <= '0;
      arb_busy                <= 1'b0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            state    <= ST_ISSUE;
            arb_busy <= 1'b1;
          end
        end
        ST_ISSUE: begin
          op                      <= lat_op;
          raw_address             <= lat_raw;
          address_offset          <= lat_off;
          common_data_bus_read_in <= lat_wdata;
          state                   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          op       <= OP_IDLE;
          arb_busy <= 1'b0;
          state    <= ST_IDLE;
          if (win_dc) begin
            dc_done <= 1'b1;
            if (lat_op == OP_READ) begin
              dc_rdata <= lat_rdata;
            end
          end else begin
            ic_done  <= 1'b1;
            ic_rdata <= lat_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] ic_cnt;
  logic [31:0] dc_cnt;
  logic [31:0] cf_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_cnt <= '0;
      dc_cnt <= '0;
      cf_cnt <= '0;
    end else begin
      if (grant_fire && grant[REQ_IC]) ic_cnt <= sat_inc(ic_cnt);
      if (grant_fire && grant[REQ_DC]) dc_cnt <= sat_inc(dc_cnt);
      if ((state == ST_IDLE) && ready && ic_req && dc_req) cf_cnt <= sat_inc(cf_cnt);
    end
  end

  assign perf_ic_grants = ic_cnt;
  assign perf_dc_grants = dc_cnt;
  assign perf_conflicts = cf_cnt;
`else
  assign perf_ic_grants = '0;
  assign perf_dc_grants = '0;
  assign perf_conflicts = '0;
`endif

endmodule
